// File: rtl/bru_pkg.sv
// Branch resolve unit shared definitions.
// Op encodings and op width for the branch condition decoder.
package bru_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_BEQ    = 3'd0;
  localparam logic [OP_W-1:0] OP_BNE    = 3'd1;
  localparam logic [OP_W-1:0] OP_BLEZ   = 3'd2;
  localparam logic [OP_W-1:0] OP_BGTZ   = 3'd3;
  localparam logic [OP_W-1:0] OP_BLTZ   = 3'd4;
  localparam logic [OP_W-1:0] OP_BGEZ   = 3'd5;
  localparam logic [OP_W-1:0] OP_ALWAYS = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD   = 3'd7;

endpackage

// File: rtl/bru_cond_eval.sv
// Branch condition evaluator (combinational).
// Signed tests use the rs sign bit plus a zero detect; rt only for BEQ/BNE.
module bru_cond_eval
  import bru_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [DATA_W-1:0] i_rs,
  input  logic [DATA_W-1:0] i_rt,
  output logic              o_taken,
  output logic              o_illegal
);

  logic w_neg;
  logic w_zero;

  assign w_neg  = i_rs[DATA_W-1];
  assign w_zero = ~|i_rs;

  // Decode the op into a taken decision or an illegal flag
  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    unique case (i_op)
      OP_BEQ:    o_taken = (i_rs == i_rt);
      OP_BNE:    o_taken = (i_rs != i_rt);
      OP_BLEZ:   o_taken = w_neg | w_zero;
      OP_BGTZ:   o_taken = ~w_neg & ~w_zero;
      OP_BLTZ:   o_taken = w_neg;
      OP_BGEZ:   o_taken = ~w_neg;
      OP_ALWAYS: o_taken = 1'b1;
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: one valid/ready register stage with flush.
// Optional retire statistics enabled by defining BRU_STATS_EN.
module branch_resolve_unit
  import bru_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic              in_pred_taken,
  input  logic [ADDR_W-1:0] in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic              out_illegal,
  output logic [ADDR_W-1:0] out_target,
  output logic [CNT_W-1:0]  stat_taken,
  output logic [CNT_W-1:0]  stat_mispred
);

  logic              r_valid;
  logic              r_taken;
  logic              r_mispred;
  logic              r_illegal;
  logic [ADDR_W-1:0] r_target;

  logic w_taken;
  logic w_illegal;
  logic w_accept;

  bru_cond_eval #(
    .DATA_W (DATA_W)
  ) u_eval (
    .i_op      (in_op),
    .i_rs      (in_rs),
    .i_rt      (in_rt),
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  assign in_ready = ~r_valid | out_ready;
  assign w_accept = in_valid & in_ready & ~flush;

  // Result register: reset, then flush, then capture, then retire
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_taken   <= 1'b0;
      r_mispred <= 1'b0;
      r_illegal <= 1'b0;
      r_target  <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_taken   <= w_taken;
      r_mispred <= w_taken ^ in_pred_taken;
      r_illegal <= w_illegal;
      r_target  <= in_target;
    end else if (r_valid && out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid      = r_valid;
  assign out_taken      = r_taken;
  assign out_mispredict = r_mispred;
  assign out_illegal    = r_illegal;
  assign out_target     = r_target;

`ifdef BRU_STATS_EN
  logic             w_retire;
  logic [CNT_W-1:0] r_stat_taken;
  logic [CNT_W-1:0] r_stat_mispred;

  assign w_retire = r_valid & out_ready & ~flush;

  // Saturating counters bumped only when a result actually retires
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_taken   <= '0;
      r_stat_mispred <= '0;
    end else if (w_retire) begin
      if (r_taken && (r_stat_taken != '1))
        r_stat_taken <= r_stat_taken + CNT_W'(1);
      if (r_mispred && (r_stat_mispred != '1))
        r_stat_mispred <= r_stat_mispred + CNT_W'(1);
    end
  end

  assign stat_taken   = r_stat_taken;
  assign stat_mispred = r_stat_mispred;
`else
  assign stat_taken   = '0;
  assign stat_mispred = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit.
// Driver pushes expected results; monitor pops on every presented result.
module tb_branch_resolve_unit;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int CW = 2;
`ifdef BRU_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic          t;
    logic          m;
    logic          i;
    logic [AW-1:0] tgt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_op = '0;
  logic [DW-1:0] in_rs = '0;
  logic [DW-1:0] in_rt = '0;
  logic          in_pred_taken = 1'b0;
  logic [AW-1:0] in_target = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_taken;
  logic          out_mispredict;
  logic          out_illegal;
  logic [AW-1:0] out_target;
  logic [CW-1:0] stat_taken;
  logic [CW-1:0] stat_mispred;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t q[$];
  bit   m_valid = 1'b0;

  branch_resolve_unit #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .CNT_W  (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_op          (in_op),
    .in_rs          (in_rs),
    .in_rt          (in_rt),
    .in_pred_taken  (in_pred_taken),
    .in_target      (in_target),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_taken      (out_taken),
    .out_mispredict (out_mispredict),
    .out_illegal    (out_illegal),
    .out_target     (out_target),
    .stat_taken     (stat_taken),
    .stat_mispred   (stat_mispred)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic ref_taken(input logic [2:0] op,
                                     input logic [DW-1:0] rs,
                                     input logic [DW-1:0] rt);
    case (op)
      3'd0:    return rs == rt;
      3'd1:    return rs != rt;
      3'd2:    return $signed(rs) <= 0;
      3'd3:    return $signed(rs) > 0;
      3'd4:    return $signed(rs) < 0;
      3'd5:    return $signed(rs) >= 0;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc(input bit v, input logic [2:0] op,
                     input logic [DW-1:0] rs, input logic [DW-1:0] rt,
                     input bit pred, input logic [AW-1:0] tgt,
                     input bit ordy, input bit fl, input bit r);
    exp_t e;
    bit   exp_rdy;
    @(negedge clk);
    rst = r; flush = fl; in_valid = v; in_op = op;
    in_rs = rs; in_rt = rt; in_pred_taken = pred;
    in_target = tgt; out_ready = ordy;
    #1;
    if (r) begin
      m_valid = 1'b0;
    end else begin
      exp_rdy = !m_valid || ordy;
      chk("in_ready", in_ready, exp_rdy);
      if (v && exp_rdy && !fl) begin
        e.t   = ref_taken(op, rs, rt);
        e.i   = (op == 3'd7);
        e.m   = e.t != pred;
        e.tgt = tgt;
        q.push_back(e);
        m_valid = 1'b1;
      end else if (fl || ordy) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Monitor: compares presented results and models saturating statistics
  initial begin : monitor
    bit            rst_prev = 1'b0;
    logic [CW-1:0] st = '0;
    logic [CW-1:0] sm = '0;
    exp_t          e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_prev) begin
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_taken", out_taken, 1'b0);
        chk("rst_misp", out_mispredict, 1'b0);
        chk("rst_ill", out_illegal, 1'b0);
        chk("rst_tgt", out_target, '0);
      end
      if (!rst_prev && !rst) begin
        chk("stat_taken", stat_taken, st);
        chk("stat_mispred", stat_mispred, sm);
      end
      if (out_valid === 1'b1 && !rst_prev) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 1'b1, 1'b0);
        end else begin
          e = q[0];
          chk("taken", out_taken, e.t);
          chk("mispredict", out_mispredict, e.m);
          chk("illegal", out_illegal, e.i);
          chk("target", out_target, e.tgt);
          if (rst) begin
          end else if (flush) begin
            void'(q.pop_front());
          end else if (out_ready) begin
            void'(q.pop_front());
            if (STATS && e.t && st != '1) st = st + 1'b1;
            if (STATS && e.m && sm != '1) sm = sm + 1'b1;
          end
        end
      end
      if (rst) begin
        q.delete();
        st = '0;
        sm = '0;
      end
      rst_prev = rst;
    end
  end

  initial begin : driver
    logic [DW-1:0] rs;
    logic [DW-1:0] rt;
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // BEQ equal, predicted not taken
    cyc(1, 0, 32'h1234, 32'h1234, 0, 32'h100, 1, 0, 0);
    // zero and most-negative rs through the sign tests
    for (int op = 2; op <= 5; op++)
      cyc(1, 3'(op), 32'h0, 32'h5, 0, 32'h200 + op, 1, 0, 0);
    for (int op = 2; op <= 5; op++)
      cyc(1, 3'(op), 32'h8000_0000, 32'h0, 1, 32'h300 + op, 1, 0, 0);
    // hold for three cycles, then back-to-back
    cyc(1, 6, 32'h1, 32'h2, 1, 32'h400, 0, 0, 0);
    cyc(1, 0, 32'h7, 32'h7, 0, 32'h404, 0, 0, 0);
    cyc(1, 0, 32'h7, 32'h7, 0, 32'h404, 0, 0, 0);
    cyc(1, 0, 32'h7, 32'h7, 0, 32'h404, 0, 0, 0);
    cyc(1, 1, 32'h7, 32'h8, 0, 32'h408, 1, 0, 0);
    // flush while holding with a new request presented
    cyc(1, 6, 32'h0, 32'h0, 0, 32'h500, 0, 0, 0);
    cyc(1, 6, 32'h0, 32'h0, 0, 32'h504, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // reserved op with prediction taken
    cyc(1, 7, 32'h9, 32'h9, 1, 32'h600, 1, 0, 0);
    // reset, then five taken mispredicts to saturate counters
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int k = 0; k < 5; k++)
      cyc(1, 6, 32'h0, 32'h0, 0, 32'h700 + k, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    // randomized traffic with rare flush and one mid-stream reset
    for (int n = 0; n < 1500; n++) begin
      rt = $urandom;
      case ($urandom_range(0, 5))
        0: rs = 32'h0;
        1: rs = 32'h8000_0000;
        2: rs = 32'hFFFF_FFFF;
        3: rs = 32'h1;
        4: rs = rt;
        default: rs = $urandom;
      endcase
      cyc($urandom_range(0, 9) < 8, 3'($urandom_range(0, 7)), rs, rt,
          1'($urandom), $urandom, $urandom_range(0, 9) < 7,
          $urandom_range(0, 19) == 0, n == 700);
    end
    for (int k = 0; k < 10 && q.size() != 0; k++)
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
    chk("drain_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
